writeback_sequencer: RTL and testbench

Writeback stage of the pipelined Y86-64 core: it accepts one retiring instruction per handshake from the memory stage and drives the register file's single write port (w_we / w_dst / w_data). Instructions that write two registers (popq) are split into two sequential writes while upstream is stalled. It also latches the first non-AOK status, freezing the pipeline, and keeps a retired-instruction count.

---
 rtl/writeback_sequencer.sv | 163 ++++++++++++++++
 tb/tb_writeback_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_sequencer.sv
// Y86-64 writeback stage: drives the single register-file write port,
// splits popq into two writes, latches halting status, counts retirements.
module writeback_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [1:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [3:0]       m_rA,
  input  logic [3:0]       m_rB,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  output logic             w_we,
  output logic [3:0]       w_dst,
  output logic [63:0]      w_data,
  output logic             halted,
  output logic [1:0]       stat_out,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    PH_E,
    PH_M,
    HALTED
  } state_e;

  localparam logic [1:0] S_AOK  = 2'b00;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  state_e           state_q;
  logic [1:0]       stat_q;
  logic [3:0]       icode_q;
  logic             cnd_q;
  logic [3:0]       ra_q;
  logic [3:0]       rb_q;
  logic [63:0]      vale_q;
  logic [63:0]      valm_q;
  logic [1:0]       sout_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_popq;
  logic        aok;
  logic        accept;
  logic        retire;
  logic        plan_we;
  logic [3:0]  plan_dst;
  logic [63:0] plan_data;

  assign is_popq = (icode_q == 4'hB);
  assign aok     = (stat_q == S_AOK);

  always_comb begin
    m_ready = 1'b0;
    unique case (state_q)
      EMPTY:  m_ready = 1'b1;
      PH_E:   m_ready = !is_popq;
      PH_M:   m_ready = 1'b1;
      HALTED: m_ready = 1'b0;
      default: m_ready = 1'b0;
    endcase
  end

  assign accept = m_valid && m_ready;
  assign retire = (state_q == PH_M) ||
                  (state_q == PH_E && aok && !is_popq);

  always_comb begin
    plan_we   = 1'b0;
    plan_dst  = R_NONE;
    plan_data = 64'd0;
    if (state_q == PH_E && aok) begin
      unique case (icode_q)
        4'h2: begin
          plan_we   = cnd_q;
          plan_dst  = rb_q;
          plan_data = vale_q;
        end
        4'h3, 4'h6: begin
          plan_we   = 1'b1;
          plan_dst  = rb_q;
          plan_data = vale_q;
        end
        4'h5: begin
          plan_we   = 1'b1;
          plan_dst  = ra_q;
          plan_data = valm_q;
        end
        4'h8, 4'h9, 4'hA, 4'hB: begin
          plan_we   = 1'b1;
          plan_dst  = R_RSP;
          plan_data = vale_q;
        end
        default: plan_we = 1'b0;
      endcase
    end else if (state_q == PH_M) begin
      plan_we   = 1'b1;
      plan_dst  = ra_q;
      plan_data = valm_q;
    end
  end

  // A write aimed at the no-register ID still burns its phase.
  assign w_we       = plan_we && (plan_dst != R_NONE);
  assign w_dst      = w_we ? plan_dst : R_NONE;
  assign w_data     = w_we ? plan_data : 64'd0;
  assign halted     = (state_q == HALTED);
  assign stat_out   = sout_q;
  assign retire_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      stat_q  <= S_AOK;
      icode_q <= 4'h1;
      cnd_q   <= 1'b0;
      ra_q    <= R_NONE;
      rb_q    <= R_NONE;
      vale_q  <= 64'd0;
      valm_q  <= 64'd0;
      sout_q  <= S_AOK;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        stat_q  <= m_stat;
        icode_q <= m_icode;
        cnd_q   <= m_cnd;
        ra_q    <= m_rA;
        rb_q    <= m_rB;
        vale_q  <= m_valE;
        valm_q  <= m_valM;
      end
      if (retire) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        sout_q <= S_AOK;
      end
      unique case (state_q)
        EMPTY: if (accept) state_q <= PH_E;
        PH_E: begin
          if (!aok) begin
            state_q <= HALTED;
            sout_q  <= stat_q;
          end else if (is_popq) begin
            state_q <= PH_M;
          end else if (accept) begin
            state_q <= PH_E;
          end else begin
            state_q <= EMPTY;
          end
        end
        PH_M: state_q <= accept ? PH_E : EMPTY;
        HALTED: state_q <= HALTED;
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer: per-cycle vector table
// plus a hand-written asynchronous-reset-during-popq sequence.
module tb_writeback_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_stat;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [3:0]  m_rA;
  logic [3:0]  m_rB;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic        w_we;
  logic [3:0]  w_dst;
  logic [63:0] w_data;
  logic        halted;
  logic [1:0]  stat_out;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  writeback_sequencer #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_stat     (m_stat),
    .m_icode    (m_icode),
    .m_cnd      (m_cnd),
    .m_rA       (m_rA),
    .m_rB       (m_rB),
    .m_valE     (m_valE),
    .m_valM     (m_valM),
    .w_we       (w_we),
    .w_dst      (w_dst),
    .w_data     (w_data),
    .halted     (halted),
    .stat_out   (stat_out),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  st;
    logic [3:0]  ic;
    logic        cnd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ve;
    logic [63:0] vm;
    logic        we;
    logic [3:0]  dst;
    logic [63:0] data;
    logic        rdy;
    logic [31:0] cnt;
    logic        hlt;
    logic [1:0]  so;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [1:0] st, input logic [3:0] ic,
    input logic cnd, input logic [3:0] ra, input logic [3:0] rb,
    input logic [63:0] ve, input logic [63:0] vm,
    input logic we, input logic [3:0] dst, input logic [63:0] data,
    input logic rdy, input logic [31:0] cnt, input logic hlt,
    input logic [1:0] so);
    vec_t r;
    r.v = v; r.st = st; r.ic = ic; r.cnd = cnd;
    r.ra = ra; r.rb = rb; r.ve = ve; r.vm = vm;
    r.we = we; r.dst = dst; r.data = data; r.rdy = rdy;
    r.cnt = cnt; r.hlt = hlt; r.so = so;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] st,
                       input logic [3:0] ic, input logic cnd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm);
    m_valid = v; m_stat = st; m_icode = ic; m_cnd = cnd;
    m_rA = ra; m_rB = rb; m_valE = ve; m_valM = vm;
  endtask

  task automatic chk_out(input string tag, input logic we,
                         input logic [3:0] dst, input logic [63:0] data,
                         input logic rdy, input logic [31:0] cnt,
                         input logic hlt, input logic [1:0] so);
    chk({tag, ".w_we"}, 64'(w_we), 64'(we));
    chk({tag, ".w_dst"}, 64'(w_dst), 64'(dst));
    chk({tag, ".w_data"}, w_data, data);
    chk({tag, ".m_ready"}, 64'(m_ready), 64'(rdy));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(cnt));
    chk({tag, ".halted"}, 64'(halted), 64'(hlt));
    chk({tag, ".stat_out"}, 64'(stat_out), 64'(so));
  endtask

  vec_t vecs[18];

  initial begin
    // Row i: outputs expected during cycle i, inputs for the edge ending it.
    vecs[0]  = mk(1,0,4'h3,0,4'hF,4'h3,64'h55,0,
                  0,4'hF,0,1,0,0,0);
    vecs[1]  = mk(1,0,4'hB,0,4'h2,4'hF,64'h108,64'hABCD,
                  1,4'h3,64'h55,1,0,0,0);
    vecs[2]  = mk(1,0,4'h6,0,4'hF,4'h5,64'h7,0,
                  1,4'h4,64'h108,0,1,0,0);
    vecs[3]  = mk(1,0,4'h6,0,4'hF,4'h5,64'h7,0,
                  1,4'h2,64'hABCD,1,1,0,0);
    vecs[4]  = mk(1,0,4'hB,0,4'h4,4'hF,64'h200,64'h99,
                  1,4'h5,64'h7,1,2,0,0);
    vecs[5]  = mk(0,0,4'h0,0,4'hF,4'hF,0,0,
                  1,4'h4,64'h200,0,3,0,0);
    vecs[6]  = mk(1,0,4'h2,0,4'hF,4'h6,64'h11,0,
                  1,4'h4,64'h99,1,3,0,0);
    vecs[7]  = mk(1,0,4'h5,0,4'hF,4'h1,0,64'h77,
                  0,4'hF,0,1,4,0,0);
    vecs[8]  = mk(1,0,4'h2,1,4'hF,4'h6,64'h66,0,
                  0,4'hF,0,1,5,0,0);
    vecs[9]  = mk(1,0,4'h8,0,4'hF,4'hF,64'h3F8,0,
                  1,4'h6,64'h66,1,6,0,0);
    vecs[10] = mk(1,0,4'h9,0,4'hF,4'hF,64'h400,0,
                  1,4'h4,64'h3F8,1,7,0,0);
    vecs[11] = mk(1,0,4'hA,0,4'h3,4'hF,64'h3F0,0,
                  1,4'h4,64'h400,1,8,0,0);
    vecs[12] = mk(1,0,4'h4,0,4'h1,4'h2,64'h10,0,
                  1,4'h4,64'h3F0,1,9,0,0);
    vecs[13] = mk(0,0,4'h0,0,4'hF,4'hF,0,0,
                  0,4'hF,0,1,10,0,0);
    vecs[14] = mk(1,2'b01,4'h0,0,4'hF,4'hF,0,0,
                  0,4'hF,0,1,11,0,0);
    vecs[15] = mk(1,0,4'h3,0,4'hF,4'h3,64'h1,0,
                  0,4'hF,0,1,11,0,0);
    vecs[16] = mk(1,0,4'h3,0,4'hF,4'h3,64'h1,0,
                  0,4'hF,0,0,11,1,2'b01);
    vecs[17] = mk(1,0,4'h3,0,4'hF,4'h3,64'h1,0,
                  0,4'hF,0,0,11,1,2'b01);

    rst_n = 1'b0;
    drive(0,0,4'h0,0,4'hF,4'hF,0,0);
    #3;
    chk_out("reset", 0, 4'hF, 0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].dst,
              vecs[i].data, vecs[i].rdy, vecs[i].cnt,
              vecs[i].hlt, vecs[i].so);
      drive(vecs[i].v, vecs[i].st, vecs[i].ic, vecs[i].cnd,
            vecs[i].ra, vecs[i].rb, vecs[i].ve, vecs[i].vm);
      @(negedge clk);
    end

    // Reset out of HALTED, then pull reset mid-cycle during a popq PH_M.
    rst_n = 1'b0;
    #1;
    chk_out("unhalt", 0, 4'hF, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1,0,4'hB,0,4'h2,4'hF,64'h108,64'hDEAD);
    @(negedge clk);
    chk_out("rpop_e", 1, 4'h4, 64'h108, 0, 0, 0, 0);
    drive(0,0,4'h0,0,4'hF,4'hF,0,0);
    @(posedge clk);
    #2;
    chk_out("rpop_m", 1, 4'h2, 64'hDEAD, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 0, 4'hF, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("post%0d", i), 0, 4'hF, 0, 1, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
